// File: rtl/clk_div_multi.sv
// Multi-channel 50%-duty clock divider / tick generator with per-channel programmable half-period.
// Optional feature: define CLKDIV_SHADOW_EN for glitch-free divisor loads via a shadow register.

module clk_div_ch #(
  parameter int CNT_W = 27,
  parameter logic [CNT_W-1:0] DEF = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] data,
  output logic             clk_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt, half;
`ifdef CLKDIV_SHADOW_EN
  logic [CNT_W-1:0] shadow;
  logic             pend;
  logic             bnd;

  // A running toggle is the only point where a new half may take effect.
  assign bnd = en & ~sync & (cnt == half);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= CNT_W'(1);
      half    <= DEF;
      clk_out <= 1'b0;
      tick    <= 1'b0;
`ifdef CLKDIV_SHADOW_EN
      shadow  <= DEF;
      pend    <= 1'b0;
`endif
    end else begin
      tick <= 1'b0;
`ifdef CLKDIV_SHADOW_EN
      if (bnd && pend) half <= shadow;
      if (we) begin
        shadow <= data;
        pend   <= 1'b1;
      end else if (bnd) begin
        pend   <= 1'b0;
      end
`else
      if (we) half <= data;
`endif
      if (sync) begin
        cnt     <= CNT_W'(1);
        clk_out <= 1'b0;
`ifndef CLKDIV_SHADOW_EN
      end else if (we) begin
        // Restart the count so a smaller half can never be overrun; clk_out holds.
        cnt     <= CNT_W'(1);
`endif
      end else if (en) begin
        if (cnt == half) begin
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          cnt     <= CNT_W'(1);
        end else begin
          cnt     <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

module clk_div_multi #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int N_CH     = 4,
  parameter int CNT_W    = 27,
  parameter int DEF_HALF = CLK_HZ / 2,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_data,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_HALF);

  logic [N_CH-1:0]  we_vec;
  logic [CNT_W-1:0] data_fix;

  // Out-of-range selects match no channel and are dropped.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < N_CH; i++)
      we_vec[i] = div_we && (div_sel == SEL_W'(i));
  end

  assign data_fix = (div_data == '0) ? CNT_W'(1) : div_data;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W), .DEF(DEF)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .we      (we_vec[g]),
      .data    (data_fix),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized and directed checks of clk_div_multi against a cycle-level behavioural model.
module tb_clk_div_multi;
  localparam int N     = 5;
  localparam int CNT_W = 27;
  localparam int HZ    = 20;
  localparam int DEFH  = HZ / 2;
  localparam int SW    = $clog2(N);
`ifdef CLKDIV_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     en = '0;
  logic             sync = 1'b0;
  logic             div_we = 1'b0;
  logic [SW-1:0]    div_sel = '0;
  logic [CNT_W-1:0] div_data = '0;
  logic [N-1:0]     clk_out, tick;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: elapsed cycles in the current half-period, level, strobe, active/pending half.
  int     el[N], mh[N], ms[N];
  bit     mp[N];
  logic [N-1:0] mc, mt;

  clk_div_multi #(.CLK_HZ(HZ), .N_CH(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_we(div_we),
    .div_sel(div_sel), .div_data(div_data), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      el[i] = 0; mh[i] = DEFH; ms[i] = DEFH; mp[i] = 1'b0;
    end
    mc = '0; mt = '0;
  endtask

  task automatic model_step();
    int dd;
    bit wr, bnd;
    dd = (div_data == 0) ? 1 : int'(div_data);
    for (int i = 0; i < N; i++) begin
      wr  = div_we && (int'(div_sel) == i);
      bnd = en[i] && !sync && (el[i] + 1 == mh[i]);
      mt[i] = 1'b0;
      if (sync) begin
        el[i] = 0; mc[i] = 1'b0;
      end else if (wr && !SHADOW) begin
        el[i] = 0;
      end else if (en[i]) begin
        if (bnd) begin
          mc[i] = ~mc[i]; mt[i] = mc[i]; el[i] = 0;
        end else begin
          el[i]++;
        end
      end
      if (!SHADOW) begin
        if (wr) mh[i] = dd;
      end else begin
        if (bnd && mp[i]) mh[i] = ms[i];
        if (wr) begin ms[i] = dd; mp[i] = 1'b1; end
        else if (bnd) mp[i] = 1'b0;
      end
    end
  endtask

  // One clock: inputs already driven; advance the model at the edge, compare at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    n_tests++;
    if (clk_out !== mc || tick !== mt) begin
      n_fail++;
      $display("FAIL %s t=%0t clk_out=%b tick=%b expected clk_out=%b tick=%b",
               tag, $time, clk_out, tick, mc, mt);
    end
  endtask

  task automatic idle_inputs();
    sync = 1'b0; div_we = 1'b0; div_sel = '0; div_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '1; idle_inputs();
    model_reset();
    #12;
    n_tests++;
    if (clk_out !== '0 || tick !== '0) begin
      n_fail++;
      $display("FAIL reset_state clk_out=%b tick=%b expected 0/0", clk_out, tick);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_period();
    for (int c = 1; c <= 32; c++) begin
      step("default_period");
      if (c == 9 || c == 10 || c == 20 || c == 30 || c == 31) begin
        n_tests++;
        if (clk_out[0] !== (c == 10 || c == 30 || c == 31) ||
            tick[0] !== (c == 10 || c == 30)) begin
          n_fail++;
          $display("FAIL default_edge cycle=%0d clk_out0=%b tick0=%b", c, clk_out[0], tick[0]);
        end
      end
    end
  endtask

  task automatic test_div_write();
    div_we = 1'b1; div_sel = SW'(1); div_data = CNT_W'(3);
    step("div_write_ch1");
    div_sel = SW'(2); div_data = '0;
    step("div_write_ch2_zero");
    div_sel = SW'(6); div_data = CNT_W'(2);
    step("div_write_out_of_range");
    idle_inputs();
    for (int c = 0; c < 30; c++) step("div_write_run");
  endtask

  task automatic test_enable();
    en[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step("enable_off");
      n_tests++;
      if (tick[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_no_tick tick0=%b expected 0", tick[0]);
      end
    end
    en[0] = 1'b1;
    for (int c = 0; c < 25; c++) step("enable_resume");
  endtask

  task automatic test_sync();
    sync = 1'b1; en = '0;
    step("sync_pulse");
    n_tests++;
    if (clk_out !== '0 || tick !== '0) begin
      n_fail++;
      $display("FAIL sync_clear clk_out=%b tick=%b expected 0/0", clk_out, tick);
    end
    sync = 1'b0; en = '1;
    for (int c = 0; c < 24; c++) step("sync_after");
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 7) != 0);
      sync     = ($urandom_range(0, 39) == 0);
      div_we   = ($urandom_range(0, 5) == 0);
      div_sel  = SW'($urandom_range(0, 7));
      div_data = CNT_W'($urandom_range(0, 6));
      step("random");
    end
    idle_inputs(); en = '1;
  endtask

  task automatic test_async_reset();
    div_we = 1'b1; div_sel = SW'(2); div_data = CNT_W'(1);
    step("arst_prep");
    idle_inputs();
    for (int c = 0; c < 5; c++) step("arst_run");
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (clk_out !== '0 || tick !== '0) begin
      n_fail++;
      $display("FAIL async_reset clk_out=%b tick=%b expected 0/0", clk_out, tick);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= DEFH; c++) step("arst_default");
    n_tests++;
    if (clk_out !== '1 || tick !== '1) begin
      n_fail++;
      $display("FAIL reset_half_restored clk_out=%b tick=%b expected all 1", clk_out, tick);
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_div_write();
    test_enable();
    test_sync();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
